// File: rtl/long_accum_pkg.sv
// Shared op_trans types and saturating-add helpers for the long accumulator.
// Arithmetic is done at MAXW bits; callers pass the result width they clamp to.
package long_accum_pkg;

    localparam int MAXW = 64;

    typedef enum logic {
        ACC = 1'b0,
        OUT = 1'b1
    } state_t;

    typedef struct packed {
        logic            clamped;
        logic [MAXW-1:0] sum;
    } sat_t;

    function automatic logic signed [MAXW:0] sat_max(input int unsigned w);
        logic signed [MAXW:0] one;
        one = (MAXW+1)'(1);
        return (one <<< (w - 1)) - one;
    endfunction

    function automatic logic signed [MAXW:0] sat_min(input int unsigned w);
        return ~sat_max(w);
    endfunction

    // a and b are already sign-extended to MAXW, so the MAXW+1 sum never wraps
    function automatic sat_t sat_add(
        input logic signed [MAXW-1:0] a,
        input logic signed [MAXW-1:0] b,
        input int unsigned            w
    );
        logic signed [MAXW:0] s;
        logic signed [MAXW:0] hi;
        logic signed [MAXW:0] lo;
        sat_t                 r;
        s  = $signed({a[MAXW-1], a}) + $signed({b[MAXW-1], b});
        hi = sat_max(w);
        lo = sat_min(w);
        r.clamped = 1'b1;
        if (s > hi) begin
            r.sum = hi[MAXW-1:0];
        end else if (s < lo) begin
            r.sum = lo[MAXW-1:0];
        end else begin
            r.clamped = 1'b0;
            r.sum     = s[MAXW-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/long_accum_sat_add.sv
// Combinational signed saturating add of a sample into the accumulator.
// ACC_WIDTH must stay below MAXW.
module long_accum_sat_add #(
    parameter int DATA_WIDTH = 14,
    parameter int ACC_WIDTH  = 24
) (
    input  logic [ACC_WIDTH-1:0]  acc,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [ACC_WIDTH-1:0]  sum,
    output logic                  clamped
);
    import long_accum_pkg::*;

    logic [MAXW-1:0] a_ext;
    logic [MAXW-1:0] d_ext;
    sat_t            r;
    logic            unused_hi;

    assign a_ext = {{(MAXW-ACC_WIDTH){acc[ACC_WIDTH-1]}}, acc};
    assign d_ext = {{(MAXW-DATA_WIDTH){din[DATA_WIDTH-1]}}, din};
    assign r = sat_add(a_ext, d_ext, ACC_WIDTH);

    assign sum       = r.sum[ACC_WIDTH-1:0];
    assign clamped   = r.clamped;
    // clamped result always fits, upper bits are pure sign extension
    assign unused_hi = ^r.sum[MAXW-1:ACC_WIDTH];

endmodule

// File: rtl/long_accum.sv
// Streaming signed accumulator: sums LEN accepted samples with saturation
// and holds each result on a valid/ready output with a sticky sat flag.
module long_accum #(
    parameter int DATA_WIDTH = 14,
    parameter int ACC_WIDTH  = 24,
    parameter int LEN        = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] datain,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_WIDTH-1:0]  dataout,
    output logic                  out_sat
);
    import long_accum_pkg::*;

    localparam int CNT_WIDTH = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(LEN - 1);

    state_t                 state;
    logic [ACC_WIDTH-1:0]   acc;
    logic [CNT_WIDTH-1:0]   cnt;
    logic                   sat;
    logic [ACC_WIDTH-1:0]   sum;
    logic                   clamped;

    long_accum_sat_add #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_sat_add (
        .acc     (acc),
        .din     (datain),
        .sum     (sum),
        .clamped (clamped)
    );

    assign in_ready = (state == ACC);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACC;
            acc       <= '0;
            cnt       <= '0;
            sat       <= 1'b0;
            out_valid <= 1'b0;
            dataout   <= '0;
            out_sat   <= 1'b0;
        end else begin
            unique case (state)
                ACC: begin
                    if (in_valid) begin
                        if (cnt == LAST) begin
                            dataout   <= sum;
                            out_sat   <= sat | clamped;
                            out_valid <= 1'b1;
                            state     <= OUT;
                            acc       <= '0;
                            cnt       <= '0;
                            sat       <= 1'b0;
                        end else begin
                            acc <= sum;
                            cnt <= cnt + 1'b1;
                            sat <= sat | clamped;
                        end
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ACC;
                    end
                end
                default: state <= ACC;
            endcase
        end
    end

endmodule

// File: tb/tb_long_accum.sv
// Scoreboard bench for long_accum: 24-bit and 16-bit accumulators
// driven in lockstep, expected sums computed by an integer model.
module tb_long_accum;

    localparam int DW  = 14;
    localparam int LEN = 16;
    localparam int WA  = 24;
    localparam int WB  = 16;

    typedef struct {
        longint d;
        bit     s;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [DW-1:0] datain;
    logic          out_ready;

    logic          in_ready_a, out_valid_a, out_sat_a;
    logic [WA-1:0] dataout_a;
    logic          in_ready_b, out_valid_b, out_sat_b;
    logic [WB-1:0] dataout_b;

    int checks = 0;
    int errors = 0;

    exp_t   qa[$];
    exp_t   qb[$];
    exp_t   ea, eb;
    longint ma, mb;
    bit     sa, sb;
    int     mcnt;

    long_accum #(.DATA_WIDTH(DW), .ACC_WIDTH(WA), .LEN(LEN)) u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready_a),
        .datain    (datain),
        .out_valid (out_valid_a),
        .out_ready (out_ready),
        .dataout   (dataout_a),
        .out_sat   (out_sat_a)
    );

    long_accum #(.DATA_WIDTH(DW), .ACC_WIDTH(WB), .LEN(LEN)) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready_b),
        .datain    (datain),
        .out_valid (out_valid_b),
        .out_ready (out_ready),
        .dataout   (dataout_b),
        .out_sat   (out_sat_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        ma = 0; mb = 0; sa = 0; sb = 0; mcnt = 0;
    endtask

    task automatic model_accept(input int v);
        longint hia, hib;
        hia = (longint'(1) << (WA-1)) - 1;
        hib = (longint'(1) << (WB-1)) - 1;
        ma += v;
        mb += v;
        if (ma > hia) begin ma = hia; sa = 1; end
        else if (ma < -hia-1) begin ma = -hia-1; sa = 1; end
        if (mb > hib) begin mb = hib; sb = 1; end
        else if (mb < -hib-1) begin mb = -hib-1; sb = 1; end
        mcnt++;
        if (mcnt == LEN) begin
            qa.push_back('{d: ma, s: sa});
            qb.push_back('{d: mb, s: sb});
            model_clear();
        end
    endtask

    task automatic send(input int v);
        int n;
        n = 0;
        in_valid = 1'b1;
        datain   = v[DW-1:0];
        @(negedge clk);
        while (!in_ready_a && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready_a) chk("in_ready_timeout", 0, 1);
        else model_accept(v);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        datain   = 'x;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid_a && out_ready) begin
                if (qa.size() == 0) chk("spurious_a", 1, 0);
                else begin
                    ea = qa.pop_front();
                    chk("sum_a", $signed(dataout_a), ea.d);
                    chk("sat_a", out_sat_a, ea.s);
                end
            end
            if (out_valid_b && out_ready) begin
                if (qb.size() == 0) chk("spurious_b", 1, 0);
                else begin
                    eb = qb.pop_front();
                    chk("sum_b", $signed(dataout_b), eb.d);
                    chk("sat_b", out_sat_b, eb.s);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        rst       = 1'b1;
        in_valid  = 1'b0;
        datain    = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        chk("rst_out_valid", out_valid_a, 0);
        chk("rst_dataout", dataout_a, 0);
        chk("rst_out_sat", out_sat_a, 0);
        chk("rst_in_ready", in_ready_a, 1);
        @(posedge clk);
        #1;

        // basic sum 1..16 = 136, single-cycle out_valid
        for (int i = 1; i <= LEN; i++) send(i);
        @(negedge clk);
        chk("basic_valid", out_valid_a, 1);
        chk("basic_in_ready_low", in_ready_a, 0);
        @(negedge clk);
        chk("basic_valid_drop", out_valid_a, 0);
        chk("basic_in_ready_back", in_ready_a, 1);
        @(posedge clk);
        #1;

        // negative full scale: 24-bit exact, 16-bit clamps at min
        for (int i = 0; i < LEN; i++) send(-8192);
        idle(2);

        // positive saturation in 16-bit, then zeros clear sticky
        for (int i = 0; i < LEN; i++) send(8191);
        idle(2);
        for (int i = 0; i < LEN; i++) send(0);
        idle(2);

        // backpressure
        out_ready = 1'b0;
        for (int i = 1; i <= LEN; i++) send(i * 10);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_valid", out_valid_a, 1);
            chk("bp_in_ready", in_ready_a, 0);
            chk("bp_dataout", $signed(dataout_a), 1360);
            chk("bp_sat", out_sat_a, 0);
            in_valid = k[0];
            datain   = 14'd555;
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        datain    = 'x;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_in_ready", in_ready_a, 0);
        @(negedge clk);
        chk("bp_in_ready_back", in_ready_a, 1);
        chk("bp_valid_drop", out_valid_a, 0);
        @(posedge clk);
        #1;
        for (int i = 0; i < LEN; i++) send(1);
        idle(2);

        // gapped input of 3s -> 48
        for (int i = 0; i < LEN; i++) begin
            send(3);
            idle($urandom_range(0, 3));
        end
        idle(2);

        // reset mid-reduction, no output for the aborted sum
        for (int i = 0; i < 7; i++) send(5);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        @(negedge clk);
        chk("midrst_valid", out_valid_a, 0);
        chk("midrst_in_ready", in_ready_a, 1);
        @(posedge clk);
        #1;
        for (int i = 0; i < LEN; i++) send(2);

        for (int i = 0; i < 20 && (qa.size() != 0 || qb.size() != 0); i++)
            @(negedge clk);
        chk("drain_a", qa.size(), 0);
        chk("drain_b", qb.size(), 0);
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
